decodificador_hamming_secded: RTL
=================================

Name: decodificador_hamming_secded

Overview:
- Parametrised, pipelined Hamming SECDED decoder. It is the successor of the fixed (15,11) single-error corrector.
- Adds an overall parity bit for double-error detection and a selectable detect-only mode.
- Uses a valid/ready stream interface with backpressure and keeps saturating error-statistics counters.
- Sits between the channel/storage receive path and the data consumer.

Parameters:
- R, 4, number of Hamming parity bits. N = 2^R-1 codeword bits; K = N-R data bits; legal range 3..6.
- CW, 16, width of each error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- entrada  in  N+1  received word. entrada[p-1] holds Hamming position p (1..N); parity bits sit at power-of-two positions; entrada[N] is the overall parity bit.
- entrada_valida  in  1  entrada is valid.
- entrada_pronta  out  1  decoder accepts a word this cycle.
- corrige_en  in  1  1 = correct single errors; 0 = detect only. Sampled with the word.
- saida  out  K  decoded data. Data positions (non-power-of-two) in ascending order; saida[0] = lowest data position (position 3).
- saida_valida  out  1  saida and flags valid.
- saida_pronta  in  1  consumer accepts.
- erro_simples  out  1  single error detected for this word.
- erro_duplo  out  1  uncorrectable (double) error detected for this word.
- limpa_contadores  in  1  synchronous clear of both counters.
- cont_simples  out  CW  count of words delivered with erro_simples=1.
- cont_duplos  out  CW  count of words delivered with erro_duplo=1.

Behaviour:
- Reset (async, rst_n=0):
  - Pipeline valid bits, saida_valida, saida, flags and counters all go to 0.
  - entrada_pronta = 1 after reset is released.
  - Reset mid-stream discards in-flight words.
- Stage 1 (on input handshake entrada_valida && entrada_pronta) registers:
  - syndrome s[R-1:0]: bit i = XOR of entrada[p-1] over all p in 1..N with bit i of p set;
  - overall parity q = XOR of entrada[N:0];
  - the word itself and corrige_en.
- Stage 2 classifies the word:
  - s=0, q=0: clean. No flags.
  - s=0, q=1: overall parity bit in error. erro_simples=1; data unchanged.
  - s≠0, q=1: single error at position s. erro_simples=1. Invert bit s-1 only if corrige_en=1. If s indexes a parity position, data is unaffected.
  - s≠0, q=0: double error. erro_duplo=1; no bit flipped; data extracted as received.
  - erro_simples and erro_duplo are never both 1.
- Latency: 2 cycles from input handshake to saida_valida when not stalled. Throughput: 1 word/cycle.
- Handshake:
  - Each stage advances when its downstream is empty or being consumed.
  - entrada_pronta = !v1 || (!v2 || saida_pronta).
  - saida, flags and saida_valida stay stable while saida_valida && !saida_pronta.
  - No word is dropped or duplicated under any stall pattern.
  - entrada_pronta may combinationally depend on saida_pronta. No combinational path from entrada to saida.
- Counters:
  - Increment on output handshake (saida_valida && saida_pronta) when the matching flag is 1.
  - Saturate at 2^CW-1; no wrap.
  - limpa_contadores has priority over a simultaneous increment; counter result is 0.
  - Counting is independent of corrige_en.

Test Plan (R=4, CW=16 unless stated):
- Clean word: entrada=16'hFFFF, saida_pronta=1 -> two cycles later saida=11'h7FF, saida_valida=1, both flags 0, counters 0.
- Single-error correction: entrada=16'hFFEF (position 5 flipped), corrige_en=1 -> saida=11'h7FF, erro_simples=1, cont_simples=1.
- Detect-only mode: entrada=16'hFFEF, corrige_en=0 -> saida=11'h7FD, erro_simples=1, erro_duplo=0.
- Double error and overall-parity error:
  - entrada=16'h0003 -> saida=11'h000, erro_duplo=1, cont_duplos=1.
  - entrada=16'h8000 -> saida=11'h000, erro_simples=1.
- Backpressure:
  - Stream 4 words back-to-back with saida_pronta=0 for 3 cycles -> entrada_pronta drops after 2 accepted words, saida held stable.
  - Release saida_pronta -> all 4 words emerge in order, none lost.
- Counters and reset:
  - CW=2, 5 single-error words -> cont_simples saturates at 3.
  - limpa_contadores asserted during an erroneous output handshake -> counter reads 0.
  - rst_n pulsed low mid-stream -> saida_valida=0 immediately; counters 0.

Source files
------------

// File: rtl/decodificador_hamming_secded.sv
// Pipelined Hamming SECDED decoder (R parity bits plus overall parity) with a
// valid/ready stream interface and saturating error-statistics counters.
module decodificador_hamming_secded #(
    parameter  int R  = 4,
    parameter  int CW = 16,
    localparam int N  = (1 << R) - 1,
    localparam int K  = N - R
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N:0]    entrada,
    input  logic          entrada_valida,
    output logic          entrada_pronta,
    input  logic          corrige_en,
    output logic [K-1:0]  saida,
    output logic          saida_valida,
    input  logic          saida_pronta,
    output logic          erro_simples,
    output logic          erro_duplo,
    input  logic          limpa_contadores,
    output logic [CW-1:0] cont_simples,
    output logic [CW-1:0] cont_duplos
);

    generate
        if (R < 3 || R > 6) begin : g_r_invalido
            $error("decodificador_hamming_secded: R must be in 3..6");
        end
    endgenerate

    function automatic logic eh_potencia_de_dois(input int unsigned p);
        return (p & (p - 1)) == 0;
    endfunction

    function automatic logic [R-1:0] calc_sindrome(input logic [N:0] w);
        logic [R-1:0] s;
        s = '0;
        for (int unsigned p = 1; p <= N; p++) begin
            for (int unsigned i = 0; i < R; i++) begin
                if (p[i]) s[i] = s[i] ^ w[p-1];
            end
        end
        return s;
    endfunction

    // Data bits live at the non-power-of-two positions, packed in ascending order.
    function automatic logic [K-1:0] extrai_dados(input logic [N-1:0] w);
        logic [K-1:0] d;
        int unsigned  k;
        d = '0;
        k = 0;
        for (int unsigned p = 1; p <= N; p++) begin
            if (!eh_potencia_de_dois(p)) begin
                d[k] = w[p-1];
                k++;
            end
        end
        return d;
    endfunction

    logic         v1, v2;
    logic [R-1:0] s1;
    logic         q1;
    logic [N-1:0] w1;
    logic         c1;

    logic         avanca1, avanca2;
    logic         aceita_entrada, entrega_saida;

    assign avanca2        = !v2 || saida_pronta;
    assign avanca1        = !v1 || avanca2;
    assign entrada_pronta = avanca1;
    assign aceita_entrada = entrada_valida && avanca1;
    assign saida_valida   = v2;
    assign entrega_saida  = v2 && saida_pronta;

    // Stage 1: syndrome, overall parity and the received word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            s1 <= '0;
            q1 <= 1'b0;
            w1 <= '0;
            c1 <= 1'b0;
        end else if (avanca1) begin
            v1 <= entrada_valida;
            if (entrada_valida) begin
                s1 <= calc_sindrome(entrada);
                q1 <= ^entrada;
                w1 <= entrada[N-1:0];
                c1 <= corrige_en;
            end
        end
    end

    logic [N-1:0] corrigida;
    logic         simples_c, duplo_c;
    logic [K-1:0] dados_c;

    always_comb begin
        corrigida = w1;
        simples_c = 1'b0;
        duplo_c   = 1'b0;
        if (s1 == '0) begin
            simples_c = q1;
        end else if (q1) begin
            simples_c = 1'b1;
            if (c1) begin
                for (int unsigned p = 1; p <= N; p++) begin
                    if (p[R-1:0] == s1) corrigida[p-1] = ~corrigida[p-1];
                end
            end
        end else begin
            duplo_c = 1'b1;
        end
        dados_c = extrai_dados(corrigida);
    end

    // Stage 2: outputs only change when the slot is empty or being consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2           <= 1'b0;
            saida        <= '0;
            erro_simples <= 1'b0;
            erro_duplo   <= 1'b0;
        end else if (avanca2) begin
            v2 <= v1;
            if (v1) begin
                saida        <= dados_c;
                erro_simples <= simples_c;
                erro_duplo   <= duplo_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont_simples <= '0;
            cont_duplos  <= '0;
        end else if (limpa_contadores) begin
            cont_simples <= '0;
            cont_duplos  <= '0;
        end else if (entrega_saida) begin
            if (erro_simples && cont_simples != '1) cont_simples <= cont_simples + 1'b1;
            if (erro_duplo && cont_duplos != '1)    cont_duplos  <= cont_duplos + 1'b1;
        end
    end

endmodule
